// File: rtl/crc8_pkg.sv
// crc8_pkg: shared CRC-8 (x^8+x^4+1, MSB-first) constants, FSM states and LFSR step
package crc8_pkg;
    localparam int CRC_W = 8;
    localparam logic [CRC_W-1:0] CRC_POLY = 8'h11;
    localparam logic [CRC_W-1:0] CRC_INIT = 8'h00;
    typedef enum logic [1:0] {IDLE, PAYLOAD, CRC} state_t;
    function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] lfsr, input logic d);
        return {lfsr[CRC_W-2:0], 1'b0} ^ ((lfsr[CRC_W-1] ^ d) ? CRC_POLY : '0);
    endfunction
endpackage

// File: rtl/crc8_serial_checker_if.sv
// crc8_serial_checker_if: serial link input and frame result outputs of the CRC-8 checker
interface crc8_serial_checker_if #(
    parameter int PAYLOAD_BITS = 8,
    parameter int ERR_CNT_W    = 8
);
    logic                    bit_in;
    logic                    bit_valid;
    logic                    sof;
    logic [PAYLOAD_BITS-1:0] payload_out;
    logic [7:0]              crc_rx;
    logic                    frame_done;
    logic                    crc_ok;
    logic                    crc_err;
    logic                    frame_abort;
    logic [ERR_CNT_W-1:0]    err_count;
    modport master (
        output bit_in, bit_valid, sof,
        input  payload_out, crc_rx, frame_done, crc_ok, crc_err, frame_abort, err_count
    );
    modport slave (
        input  bit_in, bit_valid, sof,
        output payload_out, crc_rx, frame_done, crc_ok, crc_err, frame_abort, err_count
    );
endinterface

// File: rtl/crc8_serial_lfsr.sv
// crc8_serial_lfsr: registered serial CRC-8 LFSR; clr restarts from CRC_INIT, combined with en it seeds the first bit
module crc8_serial_lfsr
    import crc8_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             d,
    output logic [CRC_W-1:0] lfsr_next
);
    logic [CRC_W-1:0] lfsr;
    assign lfsr_next = crc8_step(clr ? CRC_INIT : lfsr, d);
    always_ff @(posedge clk) begin
        if (rst) lfsr <= CRC_INIT;
        else if (en) lfsr <= lfsr_next;
        else if (clr) lfsr <= CRC_INIT;
    end
endmodule

// File: rtl/crc8_serial_checker.sv
// crc8_serial_checker: deserialises payload+CRC frames, checks CRC-8 remainder, counts bad frames
module crc8_serial_checker
    import crc8_pkg::*;
#(
    parameter int PAYLOAD_BITS = 8,
    parameter int ERR_CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    crc8_serial_checker_if.slave bus
);
    localparam int CNT_W = $clog2(PAYLOAD_BITS + 9);
    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [PAYLOAD_BITS-1:0] pay_sr;
    logic [CRC_W-2:0]        crc_sr;
    logic [CRC_W-1:0]        lfsr_next;
    logic start, acc, pay_last, last, zero;
    assign start    = bus.bit_valid & bus.sof;
    assign acc      = bus.bit_valid & ~start & (state != IDLE);
    assign pay_last = acc & (state == PAYLOAD) & (cnt == CNT_W'(PAYLOAD_BITS - 1));
    assign last     = acc & (state == CRC) & (cnt == CNT_W'(PAYLOAD_BITS + 7));
    assign zero     = lfsr_next == '0;
    // sof reseeds the LFSR from CRC_INIT and folds in bit 0 in the same cycle
    crc8_serial_lfsr u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .clr      (start),
        .en       (start | acc),
        .d        (bus.bit_in),
        .lfsr_next(lfsr_next)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            pay_sr          <= '0;
            crc_sr          <= '0;
            bus.payload_out <= '0;
            bus.crc_rx      <= '0;
            bus.err_count   <= '0;
            bus.frame_done  <= 1'b0;
            bus.crc_ok      <= 1'b0;
            bus.crc_err     <= 1'b0;
            bus.frame_abort <= 1'b0;
        end else begin
            state           <= start ? (PAYLOAD_BITS == 1 ? CRC : PAYLOAD) : pay_last ? CRC : last ? IDLE : state;
            cnt             <= start ? CNT_W'(1) : acc ? cnt + 1'b1 : cnt;
            pay_sr          <= (start | (acc & (state == PAYLOAD))) ? PAYLOAD_BITS'({pay_sr, bus.bit_in}) : pay_sr;
            crc_sr          <= (acc & (state == CRC)) ? {crc_sr[CRC_W-3:0], bus.bit_in} : crc_sr;
            bus.payload_out <= last ? pay_sr : bus.payload_out;
            bus.crc_rx      <= last ? {crc_sr, bus.bit_in} : bus.crc_rx;
            bus.err_count   <= (last & ~zero & ~&bus.err_count) ? bus.err_count + 1'b1 : bus.err_count;
            bus.frame_done  <= last;
            bus.crc_ok      <= last & zero;
            bus.crc_err     <= last & ~zero;
            bus.frame_abort <= start & (state != IDLE);
        end
    end
endmodule

// File: tb/tb_crc8_serial_checker.sv
// tb_crc8_serial_checker: directed frames checked against a frame-level long-division model every cycle
module tb_crc8_serial_checker;
    localparam int PB = 8;
    localparam int EW = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    crc8_serial_checker_if #(.PAYLOAD_BITS(PB), .ERR_CNT_W(EW)) bus ();
    crc8_serial_checker #(.PAYLOAD_BITS(PB), .ERR_CNT_W(EW)) dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0, failures = 0;
    int done_cnt = 0, ok_cnt = 0, abort_cnt = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask
    // CRC as remainder of payload*x^8 divided by 0x111
    function automatic logic [7:0] crc_div(input logic [7:0] p);
        logic [15:0] r;
        r = {p, 8'h00};
        for (int i = 15; i >= 8; i--) if (r[i]) r ^= 16'h0111 << (i - 8);
        return r[7:0];
    endfunction
    bit q[$];
    bit in_frame = 0, started = 0;
    logic m_done = 0, m_ok = 0, m_err = 0, m_abort = 0;
    logic [7:0] m_pay = 0, m_crc = 0, m_errc = 0;
    always @(posedge clk) begin
        started = 1;
        m_done = 0; m_ok = 0; m_err = 0; m_abort = 0;
        if (rst) begin
            q.delete(); in_frame = 0; m_pay = 0; m_crc = 0; m_errc = 0;
        end else if (bus.bit_valid) begin
            if (bus.sof) begin
                m_abort = in_frame;
                q.delete();
                in_frame = 1;
            end
            if (in_frame) begin
                q.push_back(bus.bit_in);
                if (q.size() == 16) begin
                    for (int k = 0; k < 8; k++) m_pay = {m_pay[6:0], q[k]};
                    for (int k = 8; k < 16; k++) m_crc = {m_crc[6:0], q[k]};
                    m_done = 1;
                    m_ok = (m_crc == crc_div(m_pay));
                    m_err = ~m_ok;
                    if (!m_ok && m_errc != 8'hFF) m_errc++;
                    in_frame = 0;
                end
            end
        end
    end
    always @(negedge clk) begin
        if (started) begin
            if (bus.frame_done) done_cnt++;
            if (bus.crc_ok) ok_cnt++;
            if (bus.frame_abort) abort_cnt++;
            chk("frame_done", bus.frame_done, m_done);
            chk("crc_ok", bus.crc_ok, m_ok);
            chk("crc_err", bus.crc_err, m_err);
            chk("frame_abort", bus.frame_abort, m_abort);
            chk("payload_out", bus.payload_out, m_pay);
            chk("crc_rx", bus.crc_rx, m_crc);
            chk("err_count", bus.err_count, m_errc);
        end
    end
    task automatic put(input logic b, input logic s, input logic v);
        bus.bit_in = b; bus.sof = s; bus.bit_valid = v;
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input int n);
        repeat (n) put(1'($urandom), 1'($urandom), 1'b0);
    endtask
    task automatic send_bits(input logic [15:0] f, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) idle($urandom_range(0, 2));
            put(f[15-i], i == 0, 1'b1);
        end
    endtask
    task automatic send_frame(input logic [7:0] p, input logic [7:0] c, input bit gaps);
        send_bits({p, c}, 16, gaps);
    endtask
    int d0, o0, a0;
    logic [7:0] snap_pay, snap_crc;
    initial begin
        bus.bit_in = 0; bus.sof = 0; bus.bit_valid = 0;
        chk("model_01", crc_div(8'h01), 8'h11);
        chk("model_80", crc_div(8'h80), 8'h08);
        chk("model_ff", crc_div(8'hFF), 8'hF0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_payload", bus.payload_out, 8'h00);
        chk("rst_err_count", bus.err_count, 8'h00);
        chk("rst_done", bus.frame_done, 1'b0);
        // 1: good frame, continuous
        send_frame(8'h01, 8'h11, 0);
        chk("t1_done", bus.frame_done, 1'b1);
        chk("t1_ok", bus.crc_ok, 1'b1);
        chk("t1_payload", bus.payload_out, 8'h01);
        chk("t1_crc_rx", bus.crc_rx, 8'h11);
        chk("t1_err_count", bus.err_count, 8'h00);
        idle(1);
        chk("t1_done_pulse", bus.frame_done, 1'b0);
        // 2: three good frames with random gaps
        d0 = done_cnt; o0 = ok_cnt;
        send_frame(8'h80, 8'h08, 1);
        chk("t2_pay80", bus.payload_out, 8'h80);
        send_frame(8'hFF, 8'hF0, 1);
        chk("t2_payff", bus.payload_out, 8'hFF);
        send_frame(8'h00, 8'h00, 1);
        chk("t2_pay00", bus.payload_out, 8'h00);
        idle(1);
        chk("t2_done_count", done_cnt - d0, 3);
        chk("t2_ok_count", ok_cnt - o0, 3);
        // 3: corrupted CRC
        send_frame(8'hFF, 8'hF1, 0);
        chk("t3_err", bus.crc_err, 1'b1);
        chk("t3_ok", bus.crc_ok, 1'b0);
        chk("t3_err_count", bus.err_count, 8'h01);
        chk("t3_payload", bus.payload_out, 8'hFF);
        chk("t3_crc_rx", bus.crc_rx, 8'hF1);
        idle(2);
        // 4: abort by new sof
        a0 = abort_cnt; d0 = done_cnt;
        send_bits(16'hA5A5, 5, 0);
        send_frame(8'h01, 8'h11, 0);
        chk("t4_ok", bus.crc_ok, 1'b1);
        chk("t4_err_count", bus.err_count, 8'h01);
        idle(1);
        chk("t4_abort_count", abort_cnt - a0, 1);
        chk("t4_done_count", done_cnt - d0, 1);
        // 5: reset mid-CRC
        d0 = done_cnt;
        send_bits({8'h55, 8'h00}, 12, 0);
        bus.bit_valid = 0;
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        chk("t5_payload", bus.payload_out, 8'h00);
        chk("t5_crc_rx", bus.crc_rx, 8'h00);
        chk("t5_err_count", bus.err_count, 8'h00);
        idle(3);
        chk("t5_no_done", done_cnt - d0, 0);
        send_frame(8'h80, 8'h08, 0);
        chk("t5_ok", bus.crc_ok, 1'b1);
        idle(1);
        // 6: saturate error counter, then stray bits in IDLE
        for (int i = 0; i < 260; i++) begin
            send_frame(8'(i), crc_div(8'(i)) ^ 8'h01, 0);
            if (i == 254) chk("t6_err_255", bus.err_count, 8'hFF);
        end
        chk("t6_err_sat", bus.err_count, 8'hFF);
        idle(1);
        snap_pay = bus.payload_out; snap_crc = bus.crc_rx; d0 = done_cnt;
        for (int i = 0; i < 10; i++) put(1'($urandom), 1'b0, 1'b1);
        idle(2);
        chk("t6_idle_payload", bus.payload_out, snap_pay);
        chk("t6_idle_crc_rx", bus.crc_rx, snap_crc);
        chk("t6_idle_done", done_cnt - d0, 0);
        chk("t6_idle_err", bus.err_count, 8'hFF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
